// File: rtl/victimcache_wb_if.sv
// Bus bundle between the L1 side (master) and the victim cache (slave).
// It carries both the lookup/insert handshake and the dirty write-back
// channel toward memory/L2, so one port on the cache covers everything
// except clk and rst.
//   mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty : requests
//   vc_rdata, rdata_dirty, rdata_exists, vc_resp                   : responses
//   wb_write, wb_address, wb_wdata (out of cache), wb_resp (in)    : write-back
interface victimcache_wb_if #(
    parameter int s_offset   = 5,
    parameter int addr_width = 32
);
    localparam int s_line = 8 * 2**s_offset;

    logic [addr_width-1:0] mem_address;
    logic                  vc_read;
    logic                  vc_write;
    logic [s_line-1:0]     mem_wdata;
    logic                  is_mem_wdata_dirty;
    logic [s_line-1:0]     vc_rdata;
    logic                  rdata_dirty;
    logic                  rdata_exists;
    logic                  vc_resp;
    logic                  wb_write;
    logic [addr_width-1:0] wb_address;
    logic [s_line-1:0]     wb_wdata;
    logic                  wb_resp;

    // The cache's own view of the bundle.
    modport slave (
        input  mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty, wb_resp,
        output vc_rdata, rdata_dirty, rdata_exists, vc_resp, wb_write, wb_address, wb_wdata
    );

    // The requester / memory side of the bundle.
    modport master (
        output mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty, wb_resp,
        input  vc_rdata, rdata_dirty, rdata_exists, vc_resp, wb_write, wb_address, wb_wdata
    );
endinterface

// File: rtl/victimcache_wb.sv
// Fully-associative victim cache with tree-PLRU replacement and write-back
// of dirty victims. A read hit hands the line back and frees the entry
// (swap semantics); an insert fills a free entry, merges into a matching
// one, or evicts the PLRU victim, writing it back first when it is dirty.
//   clk, rst : clock and synchronous active-high reset
//   bus      : victimcache_wb_if slave port (request, response, write-back)
module victimcache_wb #(
    parameter int s_offset    = 5,
    parameter int s_line      = 8 * 2**s_offset,
    parameter int addr_width  = 32,
    parameter int s_tag       = addr_width - s_offset,
    parameter int num_entries = 8,
    parameter int plru_bits   = num_entries - 1
) (
    input logic             clk,
    input logic             rst,
    victimcache_wb_if.slave bus
);
    localparam int lg = $clog2(num_entries);
    typedef logic [lg-1:0] idx_t;
    typedef enum logic [2:0] {IDLE, LOOKUP_R, LOOKUP_W, WB_WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [s_tag-1:0]       addr_q, addr_d;
    logic [s_line-1:0]      wdata_q, wdata_d;
    logic                   wdirty_q, wdirty_d;
    logic [s_tag-1:0]       tag_q  [num_entries];
    logic [s_tag-1:0]       tag_d  [num_entries];
    logic [s_line-1:0]      data_q [num_entries];
    logic [s_line-1:0]      data_d [num_entries];
    logic [num_entries-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [plru_bits-1:0]   plru_q, plru_d;
    idx_t                   victim_q, victim_d;
    logic [s_line-1:0]      vc_rdata_q, vc_rdata_d;
    logic                   rdata_dirty_q, rdata_dirty_d;
    logic                   rdata_exists_q, rdata_exists_d;
    logic                   vc_resp_q, vc_resp_d;
    logic                   wb_write_q, wb_write_d;
    logic [addr_width-1:0]  wb_address_q, wb_address_d;
    logic [s_line-1:0]      wb_wdata_q, wb_wdata_d;

    logic                   hit, free_any;
    idx_t                   hit_idx, free_idx, plru_vict;
    logic                   fill_en, fill_dirty;
    idx_t                   fill_idx;
    logic [s_offset-1:0]    unused_offset;

    assign unused_offset = bus.mem_address[s_offset-1:0];

    // Point every node on the path to idx away from it.
    function automatic logic [plru_bits-1:0] plru_touch(input logic [plru_bits-1:0] p,
                                                        input idx_t idx);
        logic [plru_bits-1:0] r;
        int node;
        logic b;
        r = p;
        node = 0;
        for (int l = 0; l < lg; l++) begin
            b = idx[lg-1-l];
            r[node] = ~b;
            node = 2 * node + 1 + int'(b);
        end
        return r;
    endfunction

    // Follow the node bits from the root; 0 selects the lower half.
    function automatic idx_t plru_victim(input logic [plru_bits-1:0] p);
        idx_t v;
        int node;
        logic b;
        v = '0;
        node = 0;
        for (int l = 0; l < lg; l++) begin
            b = p[node];
            v = (v << 1) | idx_t'(b);
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    // Parallel tag match, lowest free entry, and the PLRU candidate.
    // Tags are unique, so at most one entry can match.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = 0; i < num_entries; i++) begin
            if (valid_q[i] && tag_q[i] == addr_q) begin
                hit     = 1'b1;
                hit_idx = idx_t'(i);
            end
        end
        for (int i = num_entries - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = idx_t'(i);
            end
        end
        plru_vict = plru_victim(plru_q);
    end

    // Next-state logic. Every path that writes an entry goes through
    // fill_en so the store and the PLRU touch stay in one place.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wdirty_d       = wdirty_q;
        tag_d          = tag_q;
        data_d         = data_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        plru_d         = plru_q;
        victim_d       = victim_q;
        vc_rdata_d     = vc_rdata_q;
        rdata_dirty_d  = rdata_dirty_q;
        rdata_exists_d = rdata_exists_q;
        vc_resp_d      = 1'b0;
        wb_write_d     = wb_write_q;
        wb_address_d   = wb_address_q;
        wb_wdata_d     = wb_wdata_q;
        fill_en        = 1'b0;
        fill_idx       = '0;
        fill_dirty     = wdirty_q;

        case (state_q)
            IDLE: begin
                if (bus.vc_read) begin
                    addr_d  = bus.mem_address[addr_width-1:s_offset];
                    state_d = LOOKUP_R;
                end else if (bus.vc_write) begin
                    addr_d   = bus.mem_address[addr_width-1:s_offset];
                    wdata_d  = bus.mem_wdata;
                    wdirty_d = bus.is_mem_wdata_dirty;
                    state_d  = LOOKUP_W;
                end
            end
            LOOKUP_R: begin
                if (hit) begin
                    vc_rdata_d        = data_q[hit_idx];
                    rdata_dirty_d     = dirty_q[hit_idx];
                    rdata_exists_d    = 1'b1;
                    valid_d[hit_idx]  = 1'b0;
                    dirty_d[hit_idx]  = 1'b0;
                end else begin
                    rdata_dirty_d  = 1'b0;
                    rdata_exists_d = 1'b0;
                end
                vc_resp_d = 1'b1;
                state_d   = RESP;
            end
            LOOKUP_W: begin
                if (hit) begin
                    fill_en    = 1'b1;
                    fill_idx   = hit_idx;
                    fill_dirty = dirty_q[hit_idx] | wdirty_q;
                end else if (free_any) begin
                    fill_en  = 1'b1;
                    fill_idx = free_idx;
                end else if (!dirty_q[plru_vict]) begin
                    fill_en  = 1'b1;
                    fill_idx = plru_vict;
                end
                if (fill_en) begin
                    vc_resp_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    // Dirty victim: it must reach memory before it is overwritten.
                    victim_d     = plru_vict;
                    wb_address_d = {tag_q[plru_vict], {s_offset{1'b0}}};
                    wb_wdata_d   = data_q[plru_vict];
                    wb_write_d   = 1'b1;
                    state_d      = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (bus.wb_resp) begin
                    wb_write_d = 1'b0;
                    fill_en    = 1'b1;
                    fill_idx   = victim_q;
                    vc_resp_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fill_en) begin
            tag_d[fill_idx]   = addr_q;
            data_d[fill_idx]  = wdata_q;
            valid_d[fill_idx] = 1'b1;
            dirty_d[fill_idx] = fill_dirty;
            plru_d            = plru_touch(plru_q, fill_idx);
        end
    end

    // State and registered outputs. Reset drops any pending write-back;
    // tag and data storage need no reset because valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wdirty_q       <= 1'b0;
            valid_q        <= '0;
            dirty_q        <= '0;
            plru_q         <= '0;
            victim_q       <= '0;
            vc_rdata_q     <= '0;
            rdata_dirty_q  <= 1'b0;
            rdata_exists_q <= 1'b0;
            vc_resp_q      <= 1'b0;
            wb_write_q     <= 1'b0;
            wb_address_q   <= '0;
            wb_wdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wdirty_q       <= wdirty_d;
            tag_q          <= tag_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            plru_q         <= plru_d;
            victim_q       <= victim_d;
            vc_rdata_q     <= vc_rdata_d;
            rdata_dirty_q  <= rdata_dirty_d;
            rdata_exists_q <= rdata_exists_d;
            vc_resp_q      <= vc_resp_d;
            wb_write_q     <= wb_write_d;
            wb_address_q   <= wb_address_d;
            wb_wdata_q     <= wb_wdata_d;
        end
    end

    assign bus.vc_rdata     = vc_rdata_q;
    assign bus.rdata_dirty  = rdata_dirty_q;
    assign bus.rdata_exists = rdata_exists_q;
    assign bus.vc_resp      = vc_resp_q;
    assign bus.wb_write     = wb_write_q;
    assign bus.wb_address   = wb_address_q;
    assign bus.wb_wdata     = wb_wdata_q;
endmodule

// File: tb/tb_victimcache_wb.sv
// Directed bench for victimcache_wb: reset values, miss/hit/swap,
// in-place merge, clean and dirty PLRU eviction with write-back stall,
// read/write collision ordering, and reset during a pending write-back.
module tb_victimcache_wb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    victimcache_wb_if #(.s_offset(5), .addr_width(32)) bus ();

    victimcache_wb #(.s_offset(5), .addr_width(32), .num_entries(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct data pattern per line number.
    function automatic logic [255:0] pat(input int i);
        return {8{32'hD000_0000 + 32'(i)}};
    endfunction

    // Issue one request from a falling edge and wait (bounded) for vc_resp.
    // lat counts rising edges from acceptance to the vc_resp sample, -1 on
    // timeout. Leaves the DUT back in IDLE with the request dropped.
    task automatic vc_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] data, input logic dirty,
                          output int lat, output logic ex, output logic rdirty,
                          output logic [255:0] rdat, output logic wbseen);
        bus.vc_read            = rd;
        bus.vc_write           = wr;
        bus.mem_address        = addr;
        bus.mem_wdata          = data;
        bus.is_mem_wdata_dirty = dirty;
        lat    = -1;
        wbseen = 1'b0;
        ex     = 1'bx;
        rdirty = 1'bx;
        rdat   = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wb_write) wbseen = 1'b1;
            if (bus.vc_resp) begin
                lat    = c;
                ex     = bus.rdata_exists;
                rdirty = bus.rdata_dirty;
                rdat   = bus.vc_rdata;
                break;
            end
        end
        bus.vc_read  = 1'b0;
        bus.vc_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic ex, rd; logic [255:0] dat; logic wbs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.vc_resp !== 1'b0) begin bad++; $display("[TB] FAIL rst_vc_resp: got %b expected 0", bus.vc_resp); end
        total++; if (bus.rdata_exists !== 1'b0) begin bad++; $display("[TB] FAIL rst_exists: got %b expected 0", bus.rdata_exists); end
        total++; if (bus.rdata_dirty !== 1'b0) begin bad++; $display("[TB] FAIL rst_rdirty: got %b expected 0", bus.rdata_dirty); end
        total++; if (bus.wb_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_wb_write: got %b expected 0", bus.wb_write); end
        total++; if (bus.vc_rdata !== 256'h0) begin bad++; $display("[TB] FAIL rst_vc_rdata: got %h expected 0", bus.vc_rdata); end
        total++; if (bus.wb_address !== 32'h0) begin bad++; $display("[TB] FAIL rst_wb_address: got %h expected 0", bus.wb_address); end
        total++; if (bus.wb_wdata !== 256'h0) begin bad++; $display("[TB] FAIL rst_wb_wdata: got %h expected 0", bus.wb_wdata); end
        rst = 1'b0;
        vc_req(1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL cold_read_lat: got %0d expected 2", lat); end
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL cold_read_exists: got %b expected 0", ex); end
    endtask

    task automatic test_read_hit();
        int lat; logic ex, rd; logic [255:0] dat; logic wbs;
        vc_req(1'b0, 1'b1, 32'h0000_2040, {32{8'hA5}}, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL insert_lat: got %0d expected 2", lat); end
        vc_req(1'b1, 1'b0, 32'h0000_205F, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL hit_lat: got %0d expected 2", lat); end
        total++; if (ex !== 1'b1) begin bad++; $display("[TB] FAIL hit_exists: got %b expected 1", ex); end
        total++; if (dat !== {32{8'hA5}}) begin bad++; $display("[TB] FAIL hit_data: got %h expected a5..", dat); end
        total++; if (rd !== 1'b0) begin bad++; $display("[TB] FAIL hit_dirty: got %b expected 0", rd); end
        vc_req(1'b1, 1'b0, 32'h0000_2040, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL swap_second_read: got %b expected 0", ex); end
        total++; if (dat !== {32{8'hA5}}) begin bad++; $display("[TB] FAIL miss_holds_rdata: got %h expected a5..", dat); end
    endtask

    task automatic test_same_tag();
        int lat; logic ex, rd; logic [255:0] dat; logic wbs, wbs_any;
        vc_req(1'b0, 1'b1, 32'h0000_3000, {32{8'h11}}, 1'b1, lat, ex, rd, dat, wbs);
        wbs_any = wbs;
        vc_req(1'b0, 1'b1, 32'h0000_3000, {32{8'h22}}, 1'b0, lat, ex, rd, dat, wbs);
        wbs_any = wbs_any | wbs;
        total++; if (wbs_any !== 1'b0) begin bad++; $display("[TB] FAIL merge_no_wb: got %b expected 0", wbs_any); end
        vc_req(1'b1, 1'b0, 32'h0000_3000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (dat !== {32{8'h22}}) begin bad++; $display("[TB] FAIL merge_data: got %h expected 22..", dat); end
        total++; if (rd !== 1'b1) begin bad++; $display("[TB] FAIL merge_dirty: got %b expected 1", rd); end
    endtask

    task automatic test_fill_clean();
        int lat; logic ex, rd; logic [255:0] dat; logic wbs;
        for (int i = 0; i < 8; i++) begin
            vc_req(1'b0, 1'b1, 32'(i * 32), pat(i), 1'b0, lat, ex, rd, dat, wbs);
            total++; if (lat !== 2) begin bad++; $display("[TB] FAIL clean_fill%0d_lat: got %0d expected 2", i, lat); end
        end
        vc_req(1'b0, 1'b1, 32'h0000_0100, pat(8), 1'b0, lat, ex, rd, dat, wbs);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL clean_evict_lat: got %0d expected 2", lat); end
        total++; if (wbs !== 1'b0) begin bad++; $display("[TB] FAIL clean_evict_no_wb: got %b expected 0", wbs); end
        vc_req(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL evicted_tag0: got %b expected 0", ex); end
        vc_req(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b1) begin bad++; $display("[TB] FAIL new_line_exists: got %b expected 1", ex); end
        total++; if (dat !== pat(8)) begin bad++; $display("[TB] FAIL new_line_data: got %h expected %h", dat, pat(8)); end
    endtask

    task automatic test_dirty_writeback();
        int lat, cyc; logic ex, rd; logic [255:0] dat; logic wbs;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            vc_req(1'b0, 1'b1, 32'h0001_0000 + 32'(i * 32), pat(16 + i), 1'b1, lat, ex, rd, dat, wbs);
            total++; if (lat !== 2) begin bad++; $display("[TB] FAIL dirty_fill%0d_lat: got %0d expected 2", i, lat); end
        end
        bus.vc_write = 1'b1; bus.mem_address = 32'h0001_1000;
        bus.mem_wdata = pat(99); bus.is_mem_wdata_dirty = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.wb_write) begin cyc = c; break; end
        end
        total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL wb_start: got %0d expected 2", cyc); end
        total++; if (bus.wb_address !== 32'h0001_0000) begin bad++; $display("[TB] FAIL wb_address: got %h expected 00010000", bus.wb_address); end
        total++; if (bus.wb_wdata !== pat(16)) begin bad++; $display("[TB] FAIL wb_wdata: got %h expected %h", bus.wb_wdata, pat(16)); end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        total++; if (bus.wb_write !== 1'b1) begin bad++; $display("[TB] FAIL wb_held: got %b expected 1", bus.wb_write); end
        total++; if (bus.wb_address !== 32'h0001_0000) begin bad++; $display("[TB] FAIL wb_addr_held: got %h expected 00010000", bus.wb_address); end
        total++; if (bus.vc_resp !== 1'b0) begin bad++; $display("[TB] FAIL no_resp_in_wait: got %b expected 0", bus.vc_resp); end
        bus.wb_resp = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.wb_resp = 1'b0; bus.vc_write = 1'b0;
        total++; if (bus.vc_resp !== 1'b1) begin bad++; $display("[TB] FAIL wb_resp_to_vc_resp: got %b expected 1", bus.vc_resp); end
        total++; if (bus.wb_write !== 1'b0) begin bad++; $display("[TB] FAIL wb_write_drop: got %b expected 0", bus.wb_write); end
        @(posedge clk); @(negedge clk);
        vc_req(1'b1, 1'b0, 32'h0001_0000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL wb_victim_gone: got %b expected 0", ex); end
        vc_req(1'b1, 1'b0, 32'h0001_1000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b1 || dat !== pat(99) || rd !== 1'b0) begin bad++; $display("[TB] FAIL wb_new_line: got ex=%b d=%b %h expected ex=1 d=0 %h", ex, rd, dat, pat(99)); end
        vc_req(1'b1, 1'b0, 32'h0001_0020, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b1 || dat !== pat(17) || rd !== 1'b1) begin bad++; $display("[TB] FAIL wb_neighbour: got ex=%b d=%b %h expected ex=1 d=1 %h", ex, rd, dat, pat(17)); end
    endtask

    task automatic test_back_to_back();
        int lat, cyc; logic ex, rd; logic [255:0] dat; logic wbs;
        bus.vc_read = 1'b1; bus.vc_write = 1'b1; bus.mem_address = 32'h0002_0000;
        bus.mem_wdata = pat(50); bus.is_mem_wdata_dirty = 1'b0;
        cyc = -1; ex = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.vc_resp) begin cyc = c; ex = bus.rdata_exists; break; end
        end
        total++; if (cyc !== 2 || ex !== 1'b0) begin bad++; $display("[TB] FAIL collide_read_first: got lat=%0d ex=%b expected lat=2 ex=0", cyc, ex); end
        bus.vc_read = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.vc_resp) begin cyc = c; break; end
        end
        total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL collide_write_after: got %0d expected 3", cyc); end
        bus.vc_write = 1'b0;
        @(posedge clk); @(negedge clk);
        vc_req(1'b1, 1'b0, 32'h0002_0000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b1 || dat !== pat(50)) begin bad++; $display("[TB] FAIL collide_write_data: got ex=%b %h expected ex=1 %h", ex, dat, pat(50)); end
    endtask

    task automatic test_reset_in_wb();
        int lat, cyc; logic ex, rd; logic [255:0] dat; logic wbs;
        vc_req(1'b0, 1'b1, 32'h0003_0000, pat(60), 1'b1, lat, ex, rd, dat, wbs);
        vc_req(1'b0, 1'b1, 32'h0003_0020, pat(61), 1'b1, lat, ex, rd, dat, wbs);
        bus.vc_write = 1'b1; bus.mem_address = 32'h0003_1000;
        bus.mem_wdata = pat(62); bus.is_mem_wdata_dirty = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.wb_write) begin cyc = c; break; end
        end
        total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL full_dirty_wb: got %0d expected 2", cyc); end
        rst = 1'b1; bus.vc_write = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (bus.wb_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_drops_wb: got %b expected 0", bus.wb_write); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        vc_req(1'b1, 1'b0, 32'h0003_0000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL rst_clears_a: got %b expected 0", ex); end
        vc_req(1'b1, 1'b0, 32'h0001_0040, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL rst_clears_b: got %b expected 0", ex); end
        vc_req(1'b1, 1'b0, 32'h0003_1000, '0, 1'b0, lat, ex, rd, dat, wbs);
        total++; if (ex !== 1'b0) begin bad++; $display("[TB] FAIL rst_drops_pending: got %b expected 0", ex); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mem_address        = '0;
        bus.vc_read            = 1'b0;
        bus.vc_write           = 1'b0;
        bus.mem_wdata          = '0;
        bus.is_mem_wdata_dirty = 1'b0;
        bus.wb_resp            = 1'b0;
        test_reset();
        test_read_hit();
        test_same_tag();
        test_fill_clean();
        test_dirty_writeback();
        test_back_to_back();
        test_reset_in_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Last-resort guard in case a wait escapes its own bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
